pwm_env_sm: RTL

- Parametrised LED-fade envelope generator; successor of the single-channel 5-bit up/down PWM state machine in the knight_rider LED chain.
- Rising edge on `selected` ramps `level` from 0 up to PEAK and back down to 0, stepping once per `tick`.
- New relative to the previous generation:
  - configurable width, peak and step sizes;
  - optional hold-at-peak while selected;
  - optional retrigger during decay;
  - busy/done status;
  - integrated PWM waveform generator.

---
 rtl/pwm_env_pkg.sv | 20 ++
 rtl/pwm_gen.sv | 33 +++
 rtl/pwm_env_sm.sv | 110 +++++++++++
 3 files changed

// File: rtl/pwm_env_pkg.sv
// Shared definitions for the LED-fade envelope generator: state encoding and
// a constant log2 helper used to size the PWM counter.
package pwm_env_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    HOLD = 2'd2,
    DOWN = 2'd3
  } state_e;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter (period PEAK clocks) and registered duty comparator.
module pwm_gen
  import pwm_env_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int PEAK  = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] level,
  output logic             pwm_out
);

  localparam int               CNT_W    = clog2(PEAK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PEAK - 1);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] cnt_ext;

  assign cnt_ext = WIDTH'(cnt);

  // Counter stage feeds the compare stage; level=PEAK keeps the output high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt     <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      pwm_out <= (cnt_ext < level);
    end
  end

endmodule

// File: rtl/pwm_env_sm.sv
// LED-fade envelope state machine: ramps level 0 -> PEAK -> 0 on a rising
// edge of selected, with optional hold, retrigger and an integrated PWM.
module pwm_env_sm
  import pwm_env_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int PEAK      = 31,
  parameter int UP_STEP   = 1,
  parameter int DOWN_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             selected,
  input  logic             hold_en,
  input  logic             retrig_en,
  output logic [WIDTH-1:0] level,
  output logic             pwm_out,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0]        PEAK_L = WIDTH'(PEAK);
  localparam logic signed [WIDTH+1:0] PEAK_S = (WIDTH + 2)'(PEAK);
  localparam logic signed [WIDTH+1:0] UP_S   = (WIDTH + 2)'(UP_STEP);
  localparam logic signed [WIDTH+1:0] DN_S   = (WIDTH + 2)'(DOWN_STEP);

  // Two guard bits keep the sum and difference free of wrap.
  function automatic logic [WIDTH-1:0] sat_up(input logic [WIDTH-1:0] lvl);
    logic signed [WIDTH+1:0] sum;
    sum = $signed({2'b00, lvl}) + UP_S;
    return (sum > PEAK_S) ? PEAK_L : sum[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sat_down(input logic [WIDTH-1:0] lvl);
    logic signed [WIDTH+1:0] diff;
    diff = $signed({2'b00, lvl}) - DN_S;
    return (diff < 0) ? '0 : diff[WIDTH-1:0];
  endfunction

  state_e           state, state_nxt;
  logic [WIDTH-1:0] level_nxt, up_lvl, dn_lvl;
  logic             prev_sel, rise, done_nxt, busy_nxt;

  assign rise   = selected & ~prev_sel;
  assign up_lvl = sat_up(level);
  assign dn_lvl = sat_down(level);

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_nxt = UP;
      end
      UP: begin
        if (tick) begin
          level_nxt = up_lvl;
          if (up_lvl == PEAK_L) state_nxt = (hold_en && selected) ? HOLD : DOWN;
        end
      end
      HOLD: begin
        if (!selected || !hold_en) state_nxt = DOWN;
      end
      DOWN: begin
        // Retrigger wins over a coincident tick and leaves level untouched.
        if (rise && retrig_en) begin
          state_nxt = UP;
        end else if (tick) begin
          level_nxt = dn_lvl;
          if (dn_lvl == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // Envelope register stage; busy is registered from next_state so it tracks state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      level    <= '0;
      prev_sel <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      level    <= level_nxt;
      prev_sel <= selected;
      done     <= done_nxt;
      busy     <= busy_nxt;
    end
  end

  pwm_gen #(
    .WIDTH (WIDTH),
    .PEAK  (PEAK)
  ) u_pwm_gen (
    .clk     (clk),
    .rst     (rst),
    .level   (level),
    .pwm_out (pwm_out)
  );

endmodule
